regs_arb: RTL and testbench

Arbiter and sequencer in front of the 8080 register file (8 x 16-bit, two registered-address read ports, two write ports sharing one write enable). It clears the file after reset, then shares its ports between two requesters, A (fetch/PC path) and B (execute/writeback), using round-robin arbitration with an optional lock for multi-cycle register sequences. It also flags out-of-range register addresses and blocks their writes.

---
 rtl/regs_arb_if.sv | 28 ++
 rtl/regs_arb.sv | 151 +++++++++++++++
 tb/tb_regs_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_arb_if.sv
// Requester-side port bundle for regs_arb: one instance per requester (fetch path, execute path).
// The requester drives request, lock, addresses and write data; the arbiter returns grant and read-valid.
interface regs_arb_if;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic          req;
  logic          lock;
  logic [AW-1:0] raddr0;
  logic [AW-1:0] raddr1;
  logic          wen;
  logic [AW-1:0] waddr0;
  logic [AW-1:0] waddr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt;
  logic          rvalid;

  modport master (
    output req, lock, raddr0, raddr1, wen, waddr0, waddr1, wdata0, wdata1,
    input  gnt, rvalid
  );

  modport slave (
    input  req, lock, raddr0, raddr1, wen, waddr0, waddr1, wdata0, wdata1,
    output gnt, rvalid
  );
endinterface

// File: rtl/regs_arb.sv
// Arbiter/sequencer in front of the 8x16 register file: clears the file after reset,
// then shares it between requesters a and b round-robin with optional locking.
module regs_arb (
  input  logic        clk,
  input  logic        reset,
  regs_arb_if.slave   a,
  regs_arb_if.slave   b,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        err,
  output logic        ready,
  output logic [3:0]  rf_raddr0,
  output logic [3:0]  rf_raddr1,
  input  logic [15:0] rf_rdata0,
  input  logic [15:0] rf_rdata1,
  output logic        rf_wen,
  output logic [3:0]  rf_waddr0,
  output logic [3:0]  rf_waddr1,
  output logic [15:0] rf_wdata0,
  output logic [15:0] rf_wdata1
);
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  state_t        state;
  logic [CW-1:0] cnt;
  owner_t        owner;
  logic          last_b;
  logic          rvalid_a_q;
  logic          rvalid_b_q;
  logic          prev_bad;

  logic          run;
  logic          elig_a;
  logic          elig_b;
  logic          win_a;
  logic          win_b;
  logic          gnt_any;
  logic          bad;

  logic [AW-1:0] sel_raddr0;
  logic [AW-1:0] sel_raddr1;
  logic          sel_wen;
  logic [AW-1:0] sel_waddr0;
  logic [AW-1:0] sel_waddr1;
  logic [DW-1:0] sel_wdata0;
  logic [DW-1:0] sel_wdata1;

  // An owner excludes the other requester; the owner itself still needs req to be served.
  assign run     = (state == S_RUN);
  assign elig_a  = run && a.req && (owner != OWN_B);
  assign elig_b  = run && b.req && (owner != OWN_A);
  assign win_a   = elig_a && (!elig_b || last_b);
  assign win_b   = elig_b && (!elig_a || !last_b);
  assign gnt_any = win_a || win_b;

  assign a.gnt    = win_a;
  assign b.gnt    = win_b;
  assign a.rvalid = rvalid_a_q;
  assign b.rvalid = rvalid_b_q;

  // Winner's transaction; requester a is the default route when nobody is granted.
  always_comb begin
    sel_raddr0 = a.raddr0;
    sel_raddr1 = a.raddr1;
    sel_wen    = a.wen;
    sel_waddr0 = a.waddr0;
    sel_waddr1 = a.waddr1;
    sel_wdata0 = a.wdata0;
    sel_wdata1 = a.wdata1;
    if (win_b) begin
      sel_raddr0 = b.raddr0;
      sel_raddr1 = b.raddr1;
      sel_wen    = b.wen;
      sel_waddr0 = b.waddr0;
      sel_waddr1 = b.waddr1;
      sel_wdata0 = b.wdata0;
      sel_wdata1 = b.wdata1;
    end
  end

  // Only 8 entries exist, so any used address with bit 3 set is out of range.
  assign bad = sel_raddr0[AW-1] || sel_raddr1[AW-1] ||
               (sel_wen && (sel_waddr0[AW-1] || sel_waddr1[AW-1]));

  // File port drive: clear sequence during INIT, winner's transaction in RUN.
  always_comb begin
    rf_raddr0 = sel_raddr0;
    rf_raddr1 = sel_raddr1;
    rf_wen    = gnt_any && sel_wen && !bad;
    rf_waddr0 = sel_waddr0;
    rf_waddr1 = sel_waddr1;
    rf_wdata0 = sel_wdata0;
    rf_wdata1 = sel_wdata1;
    if (!run) begin
      rf_wen    = 1'b1;
      rf_waddr0 = {1'b0, cnt, 1'b0};
      rf_waddr1 = {1'b0, cnt, 1'b1};
      rf_wdata0 = '0;
      rf_wdata1 = '0;
    end
  end

  assign rdata0 = prev_bad ? '0 : rf_rdata0;
  assign rdata1 = prev_bad ? '0 : rf_rdata1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      cnt        <= '0;
      owner      <= OWN_NONE;
      last_b     <= 1'b1;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err        <= 1'b0;
      prev_bad   <= 1'b0;
      ready      <= 1'b0;
    end else begin
      rvalid_a_q <= win_a;
      rvalid_b_q <= win_b;
      err        <= gnt_any && bad;
      prev_bad   <= gnt_any && bad;
      case (state)
        S_INIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(3)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (win_a) begin
            last_b <= 1'b0;
            owner  <= a.lock ? OWN_A : OWN_NONE;
          end else if (win_b) begin
            last_b <= 1'b1;
            owner  <= b.lock ? OWN_B : OWN_NONE;
          end else if (owner != OWN_NONE) begin
            // No grant while owned means the owner dropped req.
            owner <= OWN_NONE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_regs_arb.sv
// Bench for regs_arb: directed test-plan steps plus random traffic, checked against a
// transaction-level model of arbitration and file contents.
module tb_regs_arb;
  logic        clk;
  logic        reset;
  logic [15:0] rdata0, rdata1;
  logic        err, ready;
  logic [3:0]  rf_raddr0, rf_raddr1;
  logic [15:0] rf_rdata0, rf_rdata1;
  logic        rf_wen;
  logic [3:0]  rf_waddr0, rf_waddr1;
  logic [15:0] rf_wdata0, rf_wdata1;

  regs_arb_if ia ();
  regs_arb_if ib ();

  regs_arb dut (
    .clk       (clk),
    .reset     (reset),
    .a         (ia),
    .b         (ib),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err       (err),
    .ready     (ready),
    .rf_raddr0 (rf_raddr0),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata0 (rf_rdata0),
    .rf_rdata1 (rf_rdata1),
    .rf_wen    (rf_wen),
    .rf_waddr0 (rf_waddr0),
    .rf_waddr1 (rf_waddr1),
    .rf_wdata0 (rf_wdata0),
    .rf_wdata1 (rf_wdata1)
  );

  always #5 clk = ~clk;

  // Register file: registered read addresses, two write ports, port 1 wins a collision.
  logic [15:0] mem [8];
  logic [3:0]  rq0, rq1;
  always @(posedge clk) begin
    if (rf_wen) begin
      mem[rf_waddr0[2:0]] <= rf_wdata0;
      mem[rf_waddr1[2:0]] <= rf_wdata1;
    end
    rq0 <= rf_raddr0;
    rq1 <= rf_raddr1;
  end
  assign rf_rdata0 = mem[rq0[2:0]];
  assign rf_rdata1 = mem[rq1[2:0]];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: clear progress, owner (0 none, 1 a, 2 b), last winner, contents, pending read.
  int          m_init;
  int          m_owner;
  int          m_last;
  logic [15:0] m_file [8];
  bit          p_valid;
  int          p_who;
  bit          p_bad;
  logic [3:0]  p_a0, p_a1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_init  = 0;
    m_owner = 0;
    m_last  = 2;
    p_valid = 0;
  endtask

  task automatic drive_a(input logic req, input logic lock, input logic [3:0] r0, input logic [3:0] r1,
                         input logic wen, input logic [3:0] w0, input logic [3:0] w1,
                         input logic [15:0] d0, input logic [15:0] d1);
    ia.req = req; ia.lock = lock; ia.raddr0 = r0; ia.raddr1 = r1;
    ia.wen = wen; ia.waddr0 = w0; ia.waddr1 = w1; ia.wdata0 = d0; ia.wdata1 = d1;
  endtask

  task automatic drive_b(input logic req, input logic lock, input logic [3:0] r0, input logic [3:0] r1,
                         input logic wen, input logic [3:0] w0, input logic [3:0] w1,
                         input logic [15:0] d0, input logic [15:0] d1);
    ib.req = req; ib.lock = lock; ib.raddr0 = r0; ib.raddr1 = r1;
    ib.wen = wen; ib.waddr0 = w0; ib.waddr1 = w1; ib.wdata0 = d0; ib.wdata1 = d1;
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 4'(8 + $urandom_range(0, 7));
    return 4'($urandom_range(0, 7));
  endfunction

  // One clock cycle: compare at the falling edge, then advance the model to the next cycle.
  task automatic run_cycle();
    int          w;
    bit          ea, eb, bad, ewen;
    logic        xl, xw;
    logic [3:0]  r0, r1, w0, w1;
    logic [15:0] d0, d1;
    @(negedge clk);
    chk("rvalid_a", 32'(ia.rvalid), 32'(p_valid && p_who == 1));
    chk("rvalid_b", 32'(ib.rvalid), 32'(p_valid && p_who == 2));
    chk("err", 32'(err), 32'(p_valid && p_bad));
    if (p_valid) begin
      chk("rdata0", 32'(rdata0), 32'(p_bad ? 16'h0 : m_file[p_a0[2:0]]));
      chk("rdata1", 32'(rdata1), 32'(p_bad ? 16'h0 : m_file[p_a1[2:0]]));
    end
    if (m_init < 4) begin
      chk("init_ready", 32'(ready), 32'(0));
      chk("init_gnt_a", 32'(ia.gnt), 32'(0));
      chk("init_gnt_b", 32'(ib.gnt), 32'(0));
      chk("init_wen", 32'(rf_wen), 32'(1));
      chk("init_waddr0", 32'(rf_waddr0), 32'(2 * m_init));
      chk("init_waddr1", 32'(rf_waddr1), 32'(2 * m_init + 1));
      chk("init_wdata0", 32'(rf_wdata0), 32'(0));
      chk("init_wdata1", 32'(rf_wdata1), 32'(0));
      m_file[3'(2 * m_init)]     = 16'h0;
      m_file[3'(2 * m_init + 1)] = 16'h0;
      m_init++;
      p_valid = 0;
    end else begin
      ea = ia.req && (m_owner == 0 || m_owner == 1);
      eb = ib.req && (m_owner == 0 || m_owner == 2);
      w = 0;
      if (ea && eb) w = (m_last == 1) ? 2 : 1;
      else if (ea)  w = 1;
      else if (eb)  w = 2;
      if (w == 2) begin
        xl = ib.lock; xw = ib.wen; r0 = ib.raddr0; r1 = ib.raddr1;
        w0 = ib.waddr0; w1 = ib.waddr1; d0 = ib.wdata0; d1 = ib.wdata1;
      end else begin
        xl = ia.lock; xw = ia.wen; r0 = ia.raddr0; r1 = ia.raddr1;
        w0 = ia.waddr0; w1 = ia.waddr1; d0 = ia.wdata0; d1 = ia.wdata1;
      end
      bad  = (int'(r0) >= 8) || (int'(r1) >= 8) || (xw && (int'(w0) >= 8 || int'(w1) >= 8));
      ewen = (w != 0) && xw && !bad;
      chk("ready", 32'(ready), 32'(1));
      chk("gnt_a", 32'(ia.gnt), 32'(w == 1));
      chk("gnt_b", 32'(ib.gnt), 32'(w == 2));
      chk("rf_wen", 32'(rf_wen), 32'(ewen));
      if (w != 0) begin
        chk("rf_raddr0", 32'(rf_raddr0), 32'(r0));
        chk("rf_raddr1", 32'(rf_raddr1), 32'(r1));
      end
      if (ewen) begin
        chk("rf_waddr0", 32'(rf_waddr0), 32'(w0));
        chk("rf_waddr1", 32'(rf_waddr1), 32'(w1));
        chk("rf_wdata0", 32'(rf_wdata0), 32'(d0));
        chk("rf_wdata1", 32'(rf_wdata1), 32'(d1));
        m_file[w0[2:0]] = d0;
        m_file[w1[2:0]] = d1;
      end
      if (w != 0) begin
        m_last  = w;
        m_owner = xl ? w : 0;
        p_valid = 1; p_who = w; p_bad = bad; p_a0 = r0; p_a1 = r1;
      end else begin
        m_owner = 0;
        p_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 4'd5, 4'd5, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    drive_b(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    model_reset();

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_a", 32'(ia.gnt), 32'(0));
    chk("rst_gnt_b", 32'(ib.gnt), 32'(0));
    chk("rst_rvalid_a", 32'(ia.rvalid), 32'(0));
    chk("rst_rvalid_b", 32'(ib.rvalid), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_rf_wen", 32'(rf_wen), 32'(1));
    chk("rst_waddr0", 32'(rf_waddr0), 32'(0));
    chk("rst_waddr1", 32'(rf_waddr1), 32'(1));
    chk("rst_wdata0", 32'(rf_wdata0), 32'(0));
    reset = 1'b0;

    // Clear sequence, then A's read of r5 in cycle 4
    repeat (5) run_cycle();
    chk("clear_r5_rvalid", 32'(ia.rvalid), 32'(1));
    chk("clear_r5_rdata0", 32'(rdata0), 32'(0));

    // Write-then-read
    drive_a(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd3, 16'h1234, 16'hBEEF);
    run_cycle();
    drive_a(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    drive_b(1'b1, 1'b0, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    run_cycle();
    chk("wr_rd_rvalid_b", 32'(ib.rvalid), 32'(1));
    chk("wr_rd_rdata0", 32'(rdata0), 32'(16'h1234));
    chk("wr_rd_rdata1", 32'(rdata1), 32'(16'hBEEF));

    // Round-robin with both requesting
    drive_a(1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    drive_b(1'b1, 1'b0, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt_a", 32'(ia.gnt), 32'(i % 2 == 0));
      run_cycle();
    end

    // Lock: A holds three cycles, releases, then B
    ia.lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_gnt_b", 32'(ib.gnt), 32'(0));
      run_cycle();
    end
    ia.lock = 1'b0;
    run_cycle();
    #1;
    chk("unlock_gnt_b", 32'(ib.gnt), 32'(1));
    run_cycle();

    // Bad write address
    drive_b(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    drive_a(1'b1, 1'b0, 4'd2, 4'd3, 1'b1, 4'd1, 4'd9, 16'hDEAD, 16'hF00D);
    #1;
    chk("bad_gnt_a", 32'(ia.gnt), 32'(1));
    chk("bad_rf_wen", 32'(rf_wen), 32'(0));
    run_cycle();
    chk("bad_err", 32'(err), 32'(1));
    chk("bad_rvalid_a", 32'(ia.rvalid), 32'(1));
    chk("bad_rdata0", 32'(rdata0), 32'(0));
    chk("bad_rdata1", 32'(rdata1), 32'(0));
    drive_a(1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    run_cycle();

    // Same-address write collision, then read back
    drive_a(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'd6, 4'd6, 16'h1111, 16'h2222);
    run_cycle();
    drive_a(1'b1, 1'b0, 4'd6, 4'd6, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    run_cycle();
    chk("collide_rdata0", 32'(rdata0), 32'(16'h2222));
    run_cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rnd_addr(), rnd_addr(),
              1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), 16'($urandom), 16'($urandom));
      drive_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rnd_addr(), rnd_addr(),
              1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), 16'($urandom), 16'($urandom));
      run_cycle();
    end

    // Reset one cycle after a grant
    drive_a(1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    drive_b(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    run_cycle();
    ia.req = 1'b1;
    run_cycle();
    chk("midrst_pre_rvalid", 32'(ia.rvalid), 32'(1));
    reset = 1'b1;
    #1;
    chk("midrst_rvalid_a", 32'(ia.rvalid), 32'(0));
    chk("midrst_err", 32'(err), 32'(0));
    chk("midrst_ready", 32'(ready), 32'(0));
    chk("midrst_rf_wen", 32'(rf_wen), 32'(1));
    chk("midrst_waddr0", 32'(rf_waddr0), 32'(0));
    chk("midrst_waddr1", 32'(rf_waddr1), 32'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive_a(1'b1, 1'b0, 4'd7, 4'd4, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
    repeat (7) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
